// File: rtl/segment_transition_ctl_if.sv
// Register-file / datapath side signals of the segment transition controller.
// The controller drives the request fields; the sequencer reports segment state back.
interface segment_transition_ctl_if #(
  parameter int unsigned RepWidth     = 16,
  parameter int unsigned SysTimeWidth = 56
);
  logic                    UPDATE_SETTINGS;
  logic                    REQ_RD_SEGMENT;
  logic [7:0]              TRANSITION_MODE;
  logic [63:0]             TRANSITION_VALUE;
  logic [RepWidth-1:0]     REP0;
  logic [RepWidth-1:0]     REP1;
  logic [SysTimeWidth-1:0] SYS_TIME;
  logic [3:0]              GPIO_IN;
  logic                    LOOP_END;
  logic                    SEGMENT;
  logic                    STOP;
  logic                    SWAP;
  logic                    BUSY;

  modport master (
    output UPDATE_SETTINGS, REQ_RD_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE,
    output REP0, REP1, SYS_TIME, GPIO_IN, LOOP_END,
    input  SEGMENT, STOP, SWAP, BUSY
  );

  modport slave (
    input  UPDATE_SETTINGS, REQ_RD_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE,
    input  REP0, REP1, SYS_TIME, GPIO_IN, LOOP_END,
    output SEGMENT, STOP, SWAP, BUSY
  );
endinterface

// File: rtl/segment_transition_ctl.sv
// Segment transition sequencer for one double-buffered playback engine:
// decides when the read segment swaps and when a finite repeat count stops playback.
module segment_transition_ctl #(
  parameter int unsigned RepWidth     = 16,
  parameter int unsigned SysTimeWidth = 56
) (
  input logic                     CLK,
  input logic                     RST,
  segment_transition_ctl_if.slave bus
);

  localparam logic [7:0] ModeSyncIdx = 8'h00;
  localparam logic [7:0] ModeSysTime = 8'h01;
  localparam logic [7:0] ModeGpio    = 8'h02;
  localparam logic [7:0] ModeExt     = 8'hF0;

  typedef enum logic {RUN, WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    seg_q, seg_d;
  logic                    stop_q, stop_d;
  logic                    swap_q, swap_d;
  logic                    auto_q, auto_d;
  logic [RepWidth-1:0]     cnt_q, cnt_d;
  logic [7:0]              mode_q, mode_d;
  logic [SysTimeWidth-1:0] value_q, value_d;
  logic                    req_seg_q, req_seg_d;
  logic [3:0]              gpio_q, gpio_d;

  logic                    trig;
  logic                    take;
  logic [RepWidth-1:0]     rep;
  logic                    unused_value_bits;

  assign unused_value_bits = ^bus.TRANSITION_VALUE[63:SysTimeWidth];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RUN;
      seg_q     <= 1'b0;
      stop_q    <= 1'b0;
      swap_q    <= 1'b0;
      auto_q    <= 1'b0;
      cnt_q     <= '0;
      mode_q    <= '0;
      value_q   <= '0;
      req_seg_q <= 1'b0;
      gpio_q    <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      stop_q    <= stop_d;
      swap_q    <= swap_d;
      auto_q    <= auto_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      value_q   <= value_d;
      req_seg_q <= req_seg_d;
      gpio_q    <= gpio_d;
    end
  end

  // Unknown mode codes fall to default and simply never fire.
  always_comb begin
    trig = 1'b0;
    if (state_q == WAIT) begin
      case (mode_q)
        ModeSyncIdx: trig = bus.LOOP_END | stop_q;
        ModeSysTime: trig = (bus.SYS_TIME >= value_q);
        ModeGpio:    trig = bus.GPIO_IN[value_q[1:0]] & ~gpio_q[value_q[1:0]];
        ModeExt:     trig = 1'b1;
        default:     trig = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    stop_d    = stop_q;
    swap_d    = 1'b0;
    auto_d    = auto_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    value_d   = value_q;
    req_seg_d = req_seg_q;
    gpio_d    = bus.GPIO_IN;
    rep       = seg_q ? bus.REP1 : bus.REP0;
    take      = trig & ~bus.UPDATE_SETTINGS;

    if (bus.LOOP_END && !stop_q && !take) begin
      if ((rep != '1) && (cnt_q == rep)) begin
        // A fresh request drops auto mode, so the limit stops instead of swapping.
        if (auto_q && !bus.UPDATE_SETTINGS) begin
          seg_d  = ~seg_q;
          swap_d = 1'b1;
          cnt_d  = '0;
        end else begin
          stop_d = 1'b1;
        end
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (bus.UPDATE_SETTINGS) begin
      state_d   = WAIT;
      auto_d    = 1'b0;
      mode_d    = bus.TRANSITION_MODE;
      value_d   = bus.TRANSITION_VALUE[SysTimeWidth-1:0];
      req_seg_d = bus.REQ_RD_SEGMENT;
    end else if (take) begin
      state_d = RUN;
      seg_d   = req_seg_q;
      swap_d  = 1'b1;
      stop_d  = 1'b0;
      cnt_d   = '0;
      auto_d  = (mode_q == ModeExt);
    end
  end

  always_comb begin
    bus.SEGMENT = seg_q;
    bus.STOP    = stop_q;
    bus.SWAP    = swap_q;
    bus.BUSY    = (state_q == WAIT);
  end

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Bench for segment_transition_ctl: directed scenarios then random traffic,
// every cycle checked against an event-level reference model.
module tb_segment_transition_ctl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  segment_transition_ctl_if bus ();

  segment_transition_ctl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: what the engine is playing and what the host has asked for.
  bit          m_seg, m_stop, m_swap;
  bit          m_pend;      // a request is waiting for its trigger
  bit          m_auto;      // EXT ping-pong after the first swap
  int          m_played;    // loops of the current segment already completed
  bit          m_rseg;
  logic [7:0]  m_mode;
  logic [63:0] m_val;
  logic [3:0]  m_gprev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_stop = 0; m_swap = 0; m_pend = 0; m_auto = 0;
    m_played = 0; m_rseg = 0; m_mode = '0; m_val = '0; m_gprev = '0;
  endtask

  task automatic check_outputs();
    check("SEGMENT", 64'(bus.SEGMENT), 64'(m_seg));
    check("STOP",    64'(bus.STOP),    64'(m_stop));
    check("SWAP",    64'(bus.SWAP),    64'(m_swap));
    check("BUSY",    64'(bus.BUSY),    64'(m_pend));
  endtask

  // One clock's worth of rules, applied to the inputs present before the edge.
  task automatic model_step();
    bit          fire, upd;
    int          limit;
    logic [1:0]  pin;
    upd  = bus.UPDATE_SETTINGS;
    pin  = m_val[1:0];
    fire = 0;
    if (m_pend) begin
      if      (m_mode == 8'h00) fire = bus.LOOP_END || m_stop;
      else if (m_mode == 8'h01) fire = (bus.SYS_TIME >= m_val[55:0]);
      else if (m_mode == 8'h02) fire = bus.GPIO_IN[pin] && !m_gprev[pin];
      else if (m_mode == 8'hF0) fire = 1;
    end
    if (upd) fire = 0;
    limit  = m_seg ? int'(bus.REP1) : int'(bus.REP0);
    m_swap = 0;
    if (fire) begin
      m_seg = m_rseg; m_swap = 1; m_played = 0; m_stop = 0;
      m_pend = 0; m_auto = (m_mode == 8'hF0);
    end else if (bus.LOOP_END && !m_stop) begin
      if (limit != 65535 && m_played == limit) begin
        if (m_auto && !upd) begin
          m_seg = !m_seg; m_swap = 1; m_played = 0;
        end else begin
          m_stop = 1;
        end
      end else begin
        m_played++;
      end
    end
    if (upd) begin
      m_pend = 1; m_auto = 0;
      m_rseg = bus.REQ_RD_SEGMENT; m_mode = bus.TRANSITION_MODE; m_val = bus.TRANSITION_VALUE;
    end
    m_gprev = bus.GPIO_IN;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  task automatic request(input bit seg, input logic [7:0] mode, input logic [63:0] val);
    bus.UPDATE_SETTINGS  = 1'b1;
    bus.REQ_RD_SEGMENT   = seg;
    bus.TRANSITION_MODE  = mode;
    bus.TRANSITION_VALUE = val;
    tick();
    bus.UPDATE_SETTINGS  = 1'b0;
  endtask

  task automatic loop_pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.LOOP_END = 1'b1;
      tick();
      bus.LOOP_END = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    bus.UPDATE_SETTINGS  = 1'b0;
    bus.REQ_RD_SEGMENT   = 1'b0;
    bus.TRANSITION_MODE  = '0;
    bus.TRANSITION_VALUE = '0;
    bus.REP0             = 16'hFFFF;
    bus.REP1             = 16'hFFFF;
    bus.SYS_TIME         = '0;
    bus.GPIO_IN          = '0;
    bus.LOOP_END         = 1'b0;
    apply_reset();
    check("rst_SEGMENT", 64'(bus.SEGMENT), 64'd0);
    check("rst_BUSY",    64'(bus.BUSY),    64'd0);

    // Infinite repeat: loop ends never stop or swap.
    loop_pulses(10, 1);
    check("inf_STOP", 64'(bus.STOP), 64'd0);

    // SYNC_IDX request completes on the next loop end.
    request(1'b1, 8'h00, 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("sync_BUSY", 64'(bus.BUSY), 64'd1);
    bus.LOOP_END = 1'b1;
    tick();
    bus.LOOP_END = 1'b0;
    check("sync_SWAP", 64'(bus.SWAP), 64'd1);
    check("sync_SEG",  64'(bus.SEGMENT), 64'd1);
    tick();

    // Finite repeat of 2 plays three loops, then a stopped engine swaps at once.
    bus.REP1 = 16'd2;
    loop_pulses(3, 2);
    check("rep_STOP", 64'(bus.STOP), 64'd1);
    loop_pulses(2, 1);
    request(1'b0, 8'h00, 64'd0);
    tick();
    check("stopswap_SWAP", 64'(bus.SWAP), 64'd1);
    check("stopswap_STOP", 64'(bus.STOP), 64'd0);

    // SYS_TIME threshold reached while waiting, then one already in the past.
    bus.SYS_TIME = 56'd990;
    request(1'b1, 8'h01, 64'hAB00_0000_0000_03E8);
    for (int t = 991; t <= 1000; t++) begin
      bus.SYS_TIME = 56'(t);
      tick();
    end
    check("time_SWAP", 64'(bus.SWAP), 64'd1);
    bus.SYS_TIME = 56'd990;
    request(1'b0, 8'h01, 64'd500);
    check("past_wait", 64'(bus.SWAP), 64'd0);
    tick();
    check("past_SWAP", 64'(bus.SWAP), 64'd1);

    // GPIO: a level high at latch is not an edge; a fresh rising edge is.
    bus.GPIO_IN = 4'b0100;
    request(1'b1, 8'h02, 64'd2);
    for (int i = 0; i < 3; i++) tick();
    check("gpio_level", 64'(bus.BUSY), 64'd1);
    bus.GPIO_IN = 4'b0000; tick();
    bus.GPIO_IN = 4'b0100; tick();
    check("gpio_SWAP", 64'(bus.SWAP), 64'd1);
    request(1'b0, 8'h02, 64'd2);
    bus.GPIO_IN = 4'b0000; tick();
    request(1'b0, 8'h37, 64'd0);
    bus.GPIO_IN = 4'b0100; tick();
    tick();
    check("replaced_BUSY", 64'(bus.BUSY), 64'd1);
    check("replaced_SEG",  64'(bus.SEGMENT), 64'd1);
    request(1'b0, 8'h01, 64'd0);
    tick();
    check("valid_SEG", 64'(bus.SEGMENT), 64'd0);

    // EXT auto mode, with a loop end landing on the initial swap.
    bus.REP0 = 16'd1;
    bus.REP1 = 16'd0;
    request(1'b0, 8'hF0, 64'd0);
    bus.LOOP_END = 1'b1;
    tick();
    bus.LOOP_END = 1'b0;
    check("ext_SWAP", 64'(bus.SWAP), 64'd1);
    loop_pulses(1, 2);
    check("ext_hold", 64'(bus.SEGMENT), 64'd0);
    loop_pulses(1, 2);
    check("ext_to1", 64'(bus.SEGMENT), 64'd1);
    loop_pulses(9, 2);
    check("ext_STOP", 64'(bus.STOP), 64'd0);

    // Reset while waiting drops the request.
    request(1'b1, 8'h00, 64'd0);
    apply_reset();
    loop_pulses(3, 1);
    check("rstwait_SEG", 64'(bus.SEGMENT), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      bus.UPDATE_SETTINGS = ($urandom_range(0, 15) == 0);
      if (bus.UPDATE_SETTINGS) begin
        bus.REQ_RD_SEGMENT = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
          0:       bus.TRANSITION_MODE = 8'h00;
          1:       bus.TRANSITION_MODE = 8'h01;
          2:       bus.TRANSITION_MODE = 8'h02;
          3:       bus.TRANSITION_MODE = 8'hF0;
          default: bus.TRANSITION_MODE = 8'h5A;
        endcase
        bus.TRANSITION_VALUE = {8'($urandom), 56'(bus.SYS_TIME + 56'($urandom_range(0, 40)))};
      end
      bus.LOOP_END = ($urandom_range(0, 3) == 0);
      bus.GPIO_IN  = 4'($urandom_range(0, 15));
      bus.SYS_TIME = bus.SYS_TIME + 56'($urandom_range(0, 2));
      if ($urandom_range(0, 149) == 0)
        bus.REP0 = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0)
        bus.REP1 = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/segment_transition_ctl.md
Name: segment_transition_ctl

Overview:
- Sequences segment swaps for one double-buffered playback engine (modulation or STM); one instance per engine.
- Takes the host's requested read segment, transition mode, transition value and per-segment repeat counts from the controller register file.
- Decides when the index generator switches segment, and when playback stops after a finite repeat count.
- Sits between the controller register block and the index/timer datapath.

Parameters:
- RepWidth, 16, width of per-segment repeat count; all-ones means infinite repetition.
- SysTimeWidth, 56, width of the system time counter and of the SYS_TIME comparison.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- UPDATE_SETTINGS  in  1  one-cycle pulse; latches REQ_RD_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE.
- REQ_RD_SEGMENT  in  1  requested segment.
- TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT.
- TRANSITION_VALUE  in  64  mode argument.
- REP0  in  RepWidth  repeat count, segment 0.
- REP1  in  RepWidth  repeat count, segment 1.
- SYS_TIME  in  SysTimeWidth  free-running system time.
- GPIO_IN  in  4  asynchronous-origin GPIO inputs, already synchronised upstream.
- LOOP_END  in  1  one-cycle pulse from the index generator when the index wraps from cycle-1 to 0.
- SEGMENT  out  1  active read segment.
- STOP  out  1  playback halted on the last sample.
- SWAP  out  1  one-cycle pulse in the cycle SEGMENT changes or restarts; index generator resets its index to 0.
- BUSY  out  1  a request is pending.

Behaviour:
- Reset: SEGMENT=0, STOP=0, SWAP=0, BUSY=0, loop counter=0, state=RUN, latched mode/value/segment=0, GPIO edge register=0.
- States:
  - RUN: current segment playing.
  - WAIT: request latched, trigger not yet met.
- UPDATE_SETTINGS:
  - Any state: latch request fields and go to WAIT with BUSY=1.
  - In WAIT, the new request replaces the pending one.
  - An unknown mode code is latched but never triggers. Stay in WAIT until a later valid request.
- Trigger conditions, evaluated in WAIT from the cycle after the latch:
  - SYNC_IDX: LOOP_END=1, or STOP=1. A stopped engine issues no LOOP_END, so a request against a stopped engine swaps the next cycle.
  - SYS_TIME: SYS_TIME >= TRANSITION_VALUE[SysTimeWidth-1:0], unsigned. If already past at latch, trigger the next cycle.
  - GPIO:
    - Trigger on a rising edge of GPIO_IN[TRANSITION_VALUE[1:0]].
    - Edge register samples every cycle.
    - A level already high at latch does not trigger.
  - EXT:
    - Swap to the latched segment immediately, the next cycle.
    - Then remain in auto mode: each time the current segment completes its repeat count, swap to the other segment.
    - Auto mode never asserts STOP.
    - A new UPDATE_SETTINGS leaves auto mode.
- On trigger, registered, taking effect 1 cycle after the trigger condition:
  - SEGMENT=latched segment; SWAP=1 for one cycle.
  - Loop counter=0, STOP=0, BUSY=0, state=RUN.
  - Requesting the already-active segment still pulses SWAP and restarts it.
- Loop counting, RUN and WAIT:
  - On LOOP_END with no simultaneous trigger, increment the loop counter.
  - Let rep be the active segment's REP.
  - If rep is not all-ones and the counter before increment equals rep: set STOP=1 and hold the counter.
  - In EXT auto mode, swap instead of setting STOP.
  - A segment therefore plays rep+1 loops.
  - LOOP_END while STOP=1 is ignored.
- Simultaneous events:
  - Trigger and LOOP_END in the same cycle: the swap wins, and the counter resets to 0, not 1.
  - UPDATE_SETTINGS and trigger of the old request in the same cycle: UPDATE_SETTINGS wins, with no swap.
- REP0/REP1 are sampled live. A change takes effect at the next LOOP_END comparison.
- Counter width is RepWidth, with no wrap: the all-ones value is never reached in finite mode.
- Reset mid-WAIT discards the pending request.

Test Plan:
1. Reset, REP0=0xFFFF, 10 LOOP_END pulses → SEGMENT=0, STOP=0, SWAP never asserted.
2. UPDATE_SETTINGS with seg=1, mode SYNC_IDX; LOOP_END 5 cycles later → BUSY=1 for those cycles; SEGMENT=1 and SWAP=1 exactly one cycle after LOOP_END; BUSY=0.
3. REP1=2, segment 1 active; 3 LOOP_END pulses → STOP=1 after the third. Then SYNC_IDX request for seg 0 → swap the next cycle, STOP=0.
4. SYS_TIME mode, value 1000, SYS_TIME stepping from 990 → SWAP in the cycle after SYS_TIME=1000. Value 500 with SYS_TIME=990 → SWAP on the second cycle after the latch.
5. GPIO mode, value 2, GPIO_IN[2] high at latch → no swap. Low then high → SWAP one cycle after the rising edge. Second UPDATE_SETTINGS while waiting → the first request is dropped.
6. EXT mode to seg 0, REP0=1, REP1=0 → swap immediately, then swaps after 2 loops on seg 0 and 1 loop on seg 1, repeating. STOP stays 0. LOOP_END coincident with a swap → counter=0.
